// File: rtl/ifetch_unit.sv
`default_nettype none
//==============================================================================
// Module   : ifetch_unit
// Purpose  : Instruction fetch front end. Accepts fetch addresses from the PC
//            register, issues one word-aligned instruction-memory request at a
//            time and buffers returned words in a small in-order queue that
//            decode drains. A flush discards the queue and any data still owed
//            by memory for the abandoned request.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
// Parameters
//   QDEPTH      instruction queue entries (power of two, >= 2)
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   pc_in       fetch address           pc_valid / pc_ready  handshake
//   flush       discard queued and in-flight fetches
//   imem_req    memory request          imem_addr  word-aligned address
//   imem_ack    memory data this cycle  imem_rdata read data
//   inst_valid  queue head valid        inst_ready decode consumes head
//   inst_out    head instruction word   inst_pc    PC of head
//   inst_fault  head entry is a misalignment fault
// Build options
//   IFETCH_ALIGN_CHECK_EN  when defined, a misaligned pc_in produces a fault
//                          entry instead of a memory request; when undefined
//                          the low address bits are ignored, inst_fault = 0.
//==============================================================================
module ifetch_unit #(
   parameter int QDEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc_in,
   input  logic        pc_valid,
   output logic        pc_ready,
   input  logic        flush,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [31:0] imem_rdata,
   output logic        inst_valid,
   input  logic        inst_ready,
   output logic [31:0] inst_out,
   output logic [31:0] inst_pc,
   output logic        inst_fault
);

   localparam int AW = $clog2(QDEPTH);
   localparam logic [AW:0]   c_DEPTH   = (AW+1)'(QDEPTH);
   localparam logic [AW:0]   c_CNT_ONE = (AW+1)'(1);
   localparam logic [AW-1:0] c_PTR_ONE = AW'(1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      REQ   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t        r_state;
   state_t        w_state_nxt;

   logic [31:0]   r_pc;
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic [31:0]   r_q_data [QDEPTH];
   logic [31:0]   r_q_pc   [QDEPTH];

   logic          w_accept;
   logic          w_latch_pc;
   logic          w_push;
   logic          w_pop;
   logic [31:0]   w_push_data;
   logic [31:0]   w_push_pc;

`ifdef IFETCH_ALIGN_CHECK_EN
   logic          r_q_fault [QDEPTH];
   logic          w_push_fault;
`endif

   //---------------------------------------------------------------------------
   // Handshakes. Outstanding requests only exist outside IDLE, so in IDLE the
   // reservation check reduces to the queue count alone. Gating with rst_n
   // keeps pc_ready low for the whole reset interval.
   //---------------------------------------------------------------------------
   assign pc_ready   = rst_n && (r_state == IDLE) && !flush && (r_count < c_DEPTH);
   assign w_accept   = pc_valid && pc_ready;
   assign inst_valid = (r_count != '0);
   // Flush wins over a pop on the same edge.
   assign w_pop      = inst_valid && inst_ready && !flush;

   assign imem_addr  = {r_pc[31:2], 2'b00};

   // Head is zeroed while empty so stale storage never leaks to decode.
   assign inst_out   = inst_valid ? r_q_data[r_rd_ptr] : 32'h0;
   assign inst_pc    = inst_valid ? r_q_pc[r_rd_ptr]   : 32'h0;
`ifdef IFETCH_ALIGN_CHECK_EN
   assign inst_fault = inst_valid ? r_q_fault[r_rd_ptr] : 1'b0;
`else
   assign inst_fault = 1'b0;
`endif

   //---------------------------------------------------------------------------
   // FSM state register
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   //---------------------------------------------------------------------------
   // FSM next state and outputs
   //---------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      imem_req    = 1'b0;
      w_latch_pc  = 1'b0;
      w_push      = 1'b0;
      w_push_data = imem_rdata;
      w_push_pc   = r_pc;
`ifdef IFETCH_ALIGN_CHECK_EN
      w_push_fault = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            if (w_accept) begin
`ifdef IFETCH_ALIGN_CHECK_EN
               if (pc_in[1:0] != 2'b00) begin
                  // Misaligned fetch: queue a fault marker, never touch memory.
                  w_push       = 1'b1;
                  w_push_data  = 32'h0;
                  w_push_pc    = pc_in;
                  w_push_fault = 1'b1;
               end else begin
                  w_latch_pc  = 1'b1;
                  w_state_nxt = REQ;
               end
`else
               w_latch_pc  = 1'b1;
               w_state_nxt = REQ;
`endif
            end
         end
         REQ: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               // A flush on the ack edge simply drops the returning word.
               w_push      = !flush;
               w_state_nxt = IDLE;
            end else if (flush) begin
               // Memory still owes us a word; keep the request up to absorb it.
               w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               w_state_nxt = IDLE;
            end
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   //---------------------------------------------------------------------------
   // Latched fetch address and queue control. Space for a returning word is
   // reserved at accept time, so a push can never find the queue full.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pc     <= 32'h0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_latch_pc) begin
            r_pc <= pc_in;
         end
         if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_push) begin
               r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
               r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
               2'b10:   r_count <= r_count + c_CNT_ONE;
               2'b01:   r_count <= r_count - c_CNT_ONE;
               default: r_count <= r_count;
            endcase
         end
      end
   end

   //---------------------------------------------------------------------------
   // Queue storage; contents are only observed while the count says valid.
   //---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_data[r_wr_ptr] <= w_push_data;
         r_q_pc[r_wr_ptr]   <= w_push_pc;
`ifdef IFETCH_ALIGN_CHECK_EN
         r_q_fault[r_wr_ptr] <= w_push_fault;
`endif
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_unit.sv
`default_nettype none
//==============================================================================
// Module   : tb_ifetch_unit
// Purpose  : Self-checking bench for ifetch_unit. Directed scenarios compare
//            against constants; a randomized run compares every cycle against
//            a transaction-level model (expected-entry queue plus a record of
//            the one request memory still owes).
// Revision : 1.0 - initial release
//==============================================================================
module tb_ifetch_unit;

   localparam int QDEPTH = 2;

   logic        clk;
   logic        rst_n;
   logic [31:0] pc_in;
   logic        pc_valid;
   logic        pc_ready;
   logic        flush;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        inst_valid;
   logic        inst_ready;
   logic [31:0] inst_out;
   logic [31:0] inst_pc;
   logic        inst_fault;

   int n_run;
   int n_fail;

   ifetch_unit #(.QDEPTH(QDEPTH)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pc_in      (pc_in),
      .pc_valid   (pc_valid),
      .pc_ready   (pc_ready),
      .flush      (flush),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_ack   (imem_ack),
      .imem_rdata (imem_rdata),
      .inst_valid (inst_valid),
      .inst_ready (inst_ready),
      .inst_out   (inst_out),
      .inst_pc    (inst_pc),
      .inst_fault (inst_fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   //---------------------------------------------------------------------------
   // Reference model
   //---------------------------------------------------------------------------
   typedef struct {
      logic [31:0] data;
      logic [31:0] pc;
      logic        fault;
   } ent_t;

   ent_t        m_q[$];
   bit          m_busy;    // a request whose data will be kept
   bit          m_drain;   // a request whose data will be thrown away
   logic [31:0] m_pc;

   logic        e_ready, e_req, e_valid, e_fault;
   logic [31:0] e_addr, e_out, e_pc;

   function automatic void model_reset();
      m_q.delete();
      m_busy  = 1'b0;
      m_drain = 1'b0;
      m_pc    = 32'h0;
   endfunction

   function automatic void model_expect();
      e_req   = m_busy || m_drain;
      e_addr  = {m_pc[31:2], 2'b00};
      e_ready = rst_n && !m_busy && !m_drain && !flush && (m_q.size() < QDEPTH);
      e_valid = (m_q.size() != 0);
      e_out   = 32'h0;
      e_pc    = 32'h0;
      e_fault = 1'b0;
      if (e_valid) begin
         e_out   = m_q[0].data;
         e_pc    = m_q[0].pc;
         e_fault = m_q[0].fault;
      end
   endfunction

   // Apply the effect of the coming clock edge given the current inputs.
   function automatic void model_edge();
      bit acc;
      bit pop;
      model_expect();
      acc = pc_valid && e_ready;
      pop = e_valid && inst_ready && !flush;
      if (flush) begin
         m_q.delete();
         if (m_busy) begin
            m_busy  = 1'b0;
            m_drain = !imem_ack;
         end else if (m_drain && imem_ack) begin
            m_drain = 1'b0;
         end
      end else begin
         if (pop) void'(m_q.pop_front());
         if (m_busy && imem_ack) begin
            m_q.push_back('{imem_rdata, m_pc, 1'b0});
            m_busy = 1'b0;
         end else if (m_drain && imem_ack) begin
            m_drain = 1'b0;
         end
         if (acc) begin
`ifdef IFETCH_ALIGN_CHECK_EN
            if (pc_in[1:0] != 2'b00) begin
               m_q.push_back('{32'h0, pc_in, 1'b1});
            end else begin
               m_busy = 1'b1;
               m_pc   = pc_in;
            end
`else
            m_busy = 1'b1;
            m_pc   = pc_in;
`endif
         end
      end
   endfunction

   // Advance one clock; returns at the following falling edge.
   task automatic step();
      if (!rst_n) model_reset();
      else        model_edge();
      @(posedge clk);
      @(negedge clk);
   endtask

   //---------------------------------------------------------------------------
   // Scenarios
   //---------------------------------------------------------------------------
   task automatic test_reset();
      @(negedge clk);
      pc_valid = 1'b1;
      pc_in    = 32'h10;
      #1;
      n_run++; if (imem_req   !== 1'b0)  begin n_fail++; $display("FAIL reset_req: got %0h want 0", imem_req); end
      n_run++; if (imem_addr  !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %08h want 0", imem_addr); end
      n_run++; if (inst_valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %0h want 0", inst_valid); end
      n_run++; if (inst_out   !== 32'h0) begin n_fail++; $display("FAIL reset_out: got %08h want 0", inst_out); end
      n_run++; if (inst_pc    !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %08h want 0", inst_pc); end
      n_run++; if (inst_fault !== 1'b0)  begin n_fail++; $display("FAIL reset_fault: got %0h want 0", inst_fault); end
      n_run++; if (pc_ready   !== 1'b0)  begin n_fail++; $display("FAIL reset_ready: got %0h want 0", pc_ready); end
      step();
      rst_n    = 1'b1;
      pc_valid = 1'b0;
      #1;
      n_run++; if (pc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %0h want 1", pc_ready); end
   endtask

   task automatic test_basic();
      pc_in = 32'h4; pc_valid = 1'b1; #1;
      n_run++; if (pc_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ready: got %0h want 1", pc_ready); end
      step();                                   // accept edge
      pc_valid = 1'b0; #1;
      n_run++; if (imem_req   !== 1'b1)  begin n_fail++; $display("FAIL basic_req: got %0h want 1", imem_req); end
      n_run++; if (imem_addr  !== 32'h4) begin n_fail++; $display("FAIL basic_addr: got %08h want 00000004", imem_addr); end
      n_run++; if (inst_valid !== 1'b0)  begin n_fail++; $display("FAIL basic_early_valid: got %0h want 0", inst_valid); end
      imem_ack = 1'b1; imem_rdata = 32'h20080005;
      step();                                   // ack edge, 2nd edge after accept
      imem_ack = 1'b0; #1;
      n_run++; if (inst_valid !== 1'b1)         begin n_fail++; $display("FAIL basic_valid: got %0h want 1", inst_valid); end
      n_run++; if (inst_out   !== 32'h20080005) begin n_fail++; $display("FAIL basic_out: got %08h want 20080005", inst_out); end
      n_run++; if (inst_pc    !== 32'h4)        begin n_fail++; $display("FAIL basic_pc: got %08h want 00000004", inst_pc); end
      n_run++; if (imem_req   !== 1'b0)         begin n_fail++; $display("FAIL basic_req_drop: got %0h want 0", imem_req); end
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0; #1;
      n_run++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pop: got %0h want 0", inst_valid); end
   endtask

   task automatic test_queue_full();
      inst_ready = 1'b0;
      pc_in = 32'h0; pc_valid = 1'b1;
      step();
      pc_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'hA0A0A0A0;
      step();
      imem_ack = 1'b0; pc_in = 32'h4; pc_valid = 1'b1; #1;
      n_run++; if (pc_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_one: got %0h want 1", pc_ready); end
      step();
      pc_valid = 1'b0; #1;
      n_run++; if (pc_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready_reserved: got %0h want 0", pc_ready); end
      imem_ack = 1'b1; imem_rdata = 32'hB1B1B1B1;
      step();
      imem_ack = 1'b0; #1;
      n_run++; if (pc_ready !== 1'b0)         begin n_fail++; $display("FAIL full_ready_full: got %0h want 0", pc_ready); end
      n_run++; if (inst_out !== 32'hA0A0A0A0) begin n_fail++; $display("FAIL full_head0: got %08h want a0a0a0a0", inst_out); end
      n_run++; if (inst_pc  !== 32'h0)        begin n_fail++; $display("FAIL full_pc0: got %08h want 0", inst_pc); end
      inst_ready = 1'b1;
      step(); #1;
      n_run++; if (pc_ready !== 1'b1)         begin n_fail++; $display("FAIL full_ready_popped: got %0h want 1", pc_ready); end
      n_run++; if (inst_out !== 32'hB1B1B1B1) begin n_fail++; $display("FAIL full_head1: got %08h want b1b1b1b1", inst_out); end
      n_run++; if (inst_pc  !== 32'h4)        begin n_fail++; $display("FAIL full_pc1: got %08h want 00000004", inst_pc); end
      step();
      inst_ready = 1'b0; #1;
      n_run++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL full_empty: got %0h want 0", inst_valid); end
   endtask

   task automatic test_flush_req();
      pc_in = 32'h8; pc_valid = 1'b1;
      step();
      pc_valid = 1'b0; flush = 1'b1;
      step();                                   // flush edge in REQ
      flush = 1'b0;
      for (int c = 0; c < 2; c++) begin
         #1;
         n_run++; if (imem_req   !== 1'b1) begin n_fail++; $display("FAIL flush_req_held%0d: got %0h want 1", c, imem_req); end
         n_run++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid%0d: got %0h want 0", c, inst_valid); end
         step();
      end
      imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
      step();
      imem_ack = 1'b0; #1;
      n_run++; if (imem_req   !== 1'b0) begin n_fail++; $display("FAIL flush_req_end: got %0h want 0", imem_req); end
      n_run++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL flush_discard: got %0h want 0", inst_valid); end
      n_run++; if (pc_ready   !== 1'b1) begin n_fail++; $display("FAIL flush_idle: got %0h want 1", pc_ready); end
   endtask

   task automatic test_back_to_back();
      pc_in = 32'h100; pc_valid = 1'b1;
      step();
      pc_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h11111111;
      step();
      imem_ack = 1'b0; pc_in = 32'h104; pc_valid = 1'b1;
      step();
      pc_valid = 1'b0; #1;
      n_run++; if (pc_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_reserved: got %0h want 0", pc_ready); end
      imem_ack = 1'b1; imem_rdata = 32'h22222222; inst_ready = 1'b1;
      step();                                   // pop and enqueue together
      imem_ack = 1'b0; inst_ready = 1'b0; #1;
      n_run++; if (inst_valid !== 1'b1)         begin n_fail++; $display("FAIL b2b_valid: got %0h want 1", inst_valid); end
      n_run++; if (inst_out   !== 32'h22222222) begin n_fail++; $display("FAIL b2b_out: got %08h want 22222222", inst_out); end
      n_run++; if (inst_pc    !== 32'h104)      begin n_fail++; $display("FAIL b2b_pc: got %08h want 00000104", inst_pc); end
      n_run++; if (pc_ready   !== 1'b1)         begin n_fail++; $display("FAIL b2b_count: got %0h want 1", pc_ready); end
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0; #1;
      n_run++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_empty: got %0h want 0", inst_valid); end
   endtask

   task automatic test_align();
      pc_in = 32'h6; pc_valid = 1'b1;
      step();
      pc_valid = 1'b0; #1;
`ifdef IFETCH_ALIGN_CHECK_EN
      n_run++; if (imem_req   !== 1'b0)  begin n_fail++; $display("FAIL align_noreq: got %0h want 0", imem_req); end
      n_run++; if (inst_valid !== 1'b1)  begin n_fail++; $display("FAIL align_valid: got %0h want 1", inst_valid); end
      n_run++; if (inst_fault !== 1'b1)  begin n_fail++; $display("FAIL align_fault: got %0h want 1", inst_fault); end
      n_run++; if (inst_pc    !== 32'h6) begin n_fail++; $display("FAIL align_pc: got %08h want 00000006", inst_pc); end
      n_run++; if (inst_out   !== 32'h0) begin n_fail++; $display("FAIL align_out: got %08h want 0", inst_out); end
`else
      n_run++; if (imem_req  !== 1'b1)  begin n_fail++; $display("FAIL align_req: got %0h want 1", imem_req); end
      n_run++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL align_addr: got %08h want 00000004", imem_addr); end
      imem_ack = 1'b1; imem_rdata = 32'hCAFEF00D;
      step();
      imem_ack = 1'b0; #1;
      n_run++; if (inst_fault !== 1'b0)         begin n_fail++; $display("FAIL align_nofault: got %0h want 0", inst_fault); end
      n_run++; if (inst_pc    !== 32'h6)        begin n_fail++; $display("FAIL align_pc: got %08h want 00000006", inst_pc); end
      n_run++; if (inst_out   !== 32'hCAFEF00D) begin n_fail++; $display("FAIL align_out: got %08h want cafef00d", inst_out); end
`endif
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
   endtask

   task automatic test_reset_mid_req();
      pc_in = 32'h40; pc_valid = 1'b1;
      step();
      pc_valid = 1'b0; #1;
      n_run++; if (imem_req !== 1'b1) begin n_fail++; $display("FAIL rstreq_pre: got %0h want 1", imem_req); end
      #1 rst_n = 1'b0; #1;
      n_run++; if (imem_req   !== 1'b0) begin n_fail++; $display("FAIL rstreq_req: got %0h want 0", imem_req); end
      n_run++; if (pc_ready   !== 1'b0) begin n_fail++; $display("FAIL rstreq_ready: got %0h want 0", pc_ready); end
      step();
      rst_n = 1'b1; imem_ack = 1'b1; imem_rdata = 32'h12345678;
      step();                                   // stray ack must be ignored
      imem_ack = 1'b0; #1;
      n_run++; if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rstreq_valid: got %0h want 0", inst_valid); end
      n_run++; if (imem_req   !== 1'b0) begin n_fail++; $display("FAIL rstreq_idle: got %0h want 0", imem_req); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 800; i++) begin
         pc_valid   = ($urandom_range(0, 1) == 1);
         pc_in      = $urandom;
         if ($urandom_range(0, 3) != 0) pc_in[1:0] = 2'b00;
         inst_ready = ($urandom_range(0, 2) != 0);
         imem_ack   = ($urandom_range(0, 2) == 0);
         imem_rdata = $urandom;
         flush      = ($urandom_range(0, 15) == 0);
         #1;
         model_expect();
         n_run++; if (pc_ready   !== e_ready) begin n_fail++; $display("FAIL rnd_ready @%0d: got %0h want %0h", i, pc_ready, e_ready); end
         n_run++; if (imem_req   !== e_req)   begin n_fail++; $display("FAIL rnd_req @%0d: got %0h want %0h", i, imem_req, e_req); end
         n_run++; if (inst_valid !== e_valid) begin n_fail++; $display("FAIL rnd_valid @%0d: got %0h want %0h", i, inst_valid, e_valid); end
         if (e_req) begin
            n_run++; if (imem_addr !== e_addr) begin n_fail++; $display("FAIL rnd_addr @%0d: got %08h want %08h", i, imem_addr, e_addr); end
         end
         if (e_valid) begin
            n_run++; if (inst_out   !== e_out)   begin n_fail++; $display("FAIL rnd_out @%0d: got %08h want %08h", i, inst_out, e_out); end
            n_run++; if (inst_pc    !== e_pc)    begin n_fail++; $display("FAIL rnd_pc @%0d: got %08h want %08h", i, inst_pc, e_pc); end
            n_run++; if (inst_fault !== e_fault) begin n_fail++; $display("FAIL rnd_fault @%0d: got %0h want %0h", i, inst_fault, e_fault); end
         end
         step();
      end
      pc_valid = 1'b0; inst_ready = 1'b0; imem_ack = 1'b0; flush = 1'b0;
   endtask

   initial begin
      n_run      = 0;
      n_fail     = 0;
      rst_n      = 1'b0;
      pc_in      = 32'h0;
      pc_valid   = 1'b0;
      flush      = 1'b0;
      imem_ack   = 1'b0;
      imem_rdata = 32'h0;
      inst_ready = 1'b0;
      model_reset();

      test_reset();
      test_basic();
      test_queue_full();
      test_flush_req();
      test_back_to_back();
      test_align();
      test_reset_mid_req();
      test_random();

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ifetch_unit.md
IFETCH_UNIT -- requirements
Module: ifetch_unit

Interface
REQ-001 SHALL have parameter QDEPTH, default 2, instruction queue entries (power of two, >=2).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port pc_in  input  32  fetch address from PC register.
REQ-005 SHALL have port pc_valid  input  1  pc_in is valid.
REQ-006 SHALL have port pc_ready  output  1  unit accepts pc_in this cycle.
REQ-007 SHALL have port flush  input  1  discard queued and in-flight fetches.
REQ-008 SHALL have port imem_req  output  1  instruction memory request.
REQ-009 SHALL have port imem_addr  output  32  word-aligned memory address.
REQ-010 SHALL have port imem_ack  input  1  memory returns data this cycle.
REQ-011 SHALL have port imem_rdata  input  32  memory read data.
REQ-012 SHALL have port inst_valid  output  1  queue head valid.
REQ-013 SHALL have port inst_ready  input  1  decode consumes head.
REQ-014 SHALL have port inst_out  output  32  head instruction word.
REQ-015 SHALL have port inst_pc  output  32  PC of head instruction.
REQ-016 SHALL have port inst_fault  output  1  head entry is a misalignment fault.

Function
REQ-017 SHALL implement FSM states IDLE, REQ, DRAIN.
REQ-018 SHALL assert pc_ready only in IDLE, flush=0, and (queue count + outstanding) < QDEPTH.
REQ-019 SHALL, on an edge with pc_valid&pc_ready, latch pc_in and enter REQ; imem_req=1 from the next cycle.
REQ-020 SHALL hold imem_req=1 and imem_addr constant ({pc[31:2],2'b00}) in REQ until imem_ack=1.
REQ-021 SHALL, on the REQ edge with imem_ack=1, enqueue {imem_rdata, latched pc, fault=0} and return to IDLE; imem_req=0 next cycle.
REQ-022 SHALL therefore give minimum latency 2 cycles from accept edge to inst_valid=1 (ack in first REQ cycle).
REQ-023 SHALL ignore imem_ack outside REQ and DRAIN.
REQ-024 SHALL present queue head combinationally on inst_out/inst_pc/inst_fault; pop on edge with inst_valid&inst_ready; FIFO order preserved.
REQ-025 SHALL allow enqueue and pop on the same edge; count unchanged; no overflow possible because space is reserved at accept.
REQ-026 SHALL, on flush in IDLE, empty the queue at that edge (inst_valid=0 next cycle).
REQ-027 SHALL, on flush in REQ, empty the queue, keep imem_req=1, enter DRAIN; in DRAIN discard data on imem_ack and go to IDLE; flush in REQ on the ack edge discards that data and goes directly to IDLE.
REQ-028 SHALL give flush priority over pc_valid, enqueue and pop on the same edge.
REQ-029 SHALL wrap queue pointers modulo QDEPTH.

Reset
REQ-030 SHALL, on rst_n=0, immediately force state IDLE, queue empty, imem_req=0, imem_addr=0, inst_valid=0, inst_out=0, inst_pc=0, inst_fault=0, pc_ready=0 while rst_n=0.
REQ-031 SHALL abandon any in-flight request on reset; a later imem_ack before a new request SHALL be ignored.

Configuration
REQ-032 SHALL honour macro IFETCH_ALIGN_CHECK_EN.
REQ-033 SHALL, when defined, on accepting pc_in with pc_in[1:0]!=0, issue no memory request, enqueue {32'h00000000, pc_in, fault=1} at the next edge, remain IDLE.
REQ-034 SHALL, when undefined, ignore pc_in[1:0] (request address word-aligned), tie inst_fault=0.

Verification
REQ-035 SHALL cover: reset released, pc_in=0x00000004 valid, ack in first REQ cycle with rdata=0x20080005 -> imem_addr=0x4, inst_valid=1 two cycles after accept, inst_out=0x20080005, inst_pc=0x4.
REQ-036 SHALL cover: inst_ready=0, fetch 0x0,0x4 (QDEPTH=2) -> pc_ready=0 after 2nd accept; pop -> pc_ready=1; outputs in order.
REQ-037 SHALL cover: flush during REQ, ack 3 cycles later with 0xDEADBEEF -> imem_req held until ack, inst_valid stays 0, IDLE after ack.
REQ-038 SHALL cover: rst_n low mid-REQ -> imem_req=0 immediately; ack after release ignored, queue empty.
REQ-039 SHALL cover: with IFETCH_ALIGN_CHECK_EN, pc_in=0x00000006 -> no imem_req, inst_fault=1, inst_pc=0x6; without it -> imem_addr=0x4, inst_fault=0.
REQ-040 SHALL cover: queue full, simultaneous pop and ack -> count unchanged, no entry lost.
